// File: rtl/tone_mixer_nch.sv
// tone_mixer_nch: NUM_CH square-wave tone channels mixed into saturated
// signed stereo samples, plus a programmable tempo strobe and beat counter.
// Optional feature: define TONE_PAN_EN to route each channel by note_pan;
// without it note_pan is ignored and both sides carry the same mix.
module tone_mixer_nch #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 20,
  parameter int SAMPLE_W = 16,
  parameter int TEMPO_W  = 26,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       note_valid,
  output logic                       note_ready,
  input  logic [CH_W-1:0]            note_ch,
  input  logic [DIV_W-1:0]           note_period,
  input  logic [3:0]                 note_vol,
  input  logic [1:0]                 note_pan,
  input  logic [TEMPO_W-1:0]         tempo_period,
  output logic signed [SAMPLE_W-1:0] LData,
  output logic signed [SAMPLE_W-1:0] RData,
  output logic                       tempo,
  output logic [7:0]                 beat_cnt
);

  // Mix accumulator: 8 channels of |A| < 2^(SAMPLE_W-1) fit in SAMPLE_W+3 bits
  localparam int MIX_W = SAMPLE_W + 3;

  // Active and pending per-channel registers
  logic [DIV_W-1:0] r_period  [NUM_CH];
  logic [3:0]       r_vol     [NUM_CH];
  logic [DIV_W-1:0] r_cnt     [NUM_CH];
  logic             r_phase   [NUM_CH];
  logic             r_pend    [NUM_CH];
  logic [DIV_W-1:0] r_pperiod [NUM_CH];
  logic [3:0]       r_pvol    [NUM_CH];
`ifdef TONE_PAN_EN
  logic [1:0]       r_pan     [NUM_CH];
  logic [1:0]       r_ppan    [NUM_CH];
`else
  logic             w_unused_pan;
  assign w_unused_pan = ^note_pan;
`endif

  logic                    w_ready;
  logic [NUM_CH-1:0]       w_wr;
  logic signed [MIX_W-1:0] w_lsum;
  logic signed [MIX_W-1:0] w_rsum;
  logic [TEMPO_W-1:0]      r_tcnt;

  // Signed channel contribution: +/- vol * 2^(SAMPLE_W-5)
  function automatic logic signed [MIX_W-1:0] chan_amp(input logic [3:0] vol,
                                                       input logic       neg);
    logic signed [MIX_W-1:0] mag;
    mag = $signed({{(MIX_W-4){1'b0}}, vol}) << (SAMPLE_W - 5);
    return neg ? -mag : mag;
  endfunction

  // Clamp the wide mix to the signed SAMPLE_W output range
  function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [MIX_W-1:0] x);
    logic signed [MIX_W-1:0] hi;
    logic signed [MIX_W-1:0] lo;
    hi = $signed({{4{1'b0}}, {(SAMPLE_W-1){1'b1}}});
    lo = $signed({{4{1'b1}}, {(SAMPLE_W-1){1'b0}}});
    if (x > hi)      return hi[SAMPLE_W-1:0];
    else if (x < lo) return lo[SAMPLE_W-1:0];
    else             return x[SAMPLE_W-1:0];
  endfunction

  // Ready drops only while the addressed channel holds a pending update
  always_comb begin
    w_ready = 1'b1;
    w_wr    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (note_ch == CH_W'(i) && r_pend[i]) w_ready = 1'b0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      w_wr[i] = note_valid && w_ready && (note_ch == CH_W'(i));
    end
  end

  assign note_ready = w_ready;

  // Channel counters, phase toggling and glitch-free retune at boundaries
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_period[i]  <= '0;
        r_vol[i]     <= '0;
        r_cnt[i]     <= '0;
        r_phase[i]   <= 1'b0;
        r_pend[i]    <= 1'b0;
        r_pperiod[i] <= '0;
        r_pvol[i]    <= '0;
`ifdef TONE_PAN_EN
        r_pan[i]     <= '0;
        r_ppan[i]    <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_period[i] == '0) begin
          // silent channel: a write takes effect immediately
          if (w_wr[i]) begin
            r_period[i] <= note_period;
            r_vol[i]    <= note_vol;
`ifdef TONE_PAN_EN
            r_pan[i]    <= note_pan;
`endif
            r_cnt[i]    <= '0;
            r_phase[i]  <= 1'b0;
          end
        end else begin
          if (r_cnt[i] == r_period[i] - 1'b1) begin
            r_cnt[i] <= '0;
            if (r_pend[i]) begin
              r_period[i] <= r_pperiod[i];
              r_vol[i]    <= r_pvol[i];
`ifdef TONE_PAN_EN
              r_pan[i]    <= r_ppan[i];
`endif
              r_pend[i]   <= 1'b0;
              // a pending period of 0 parks the channel at phase 0
              r_phase[i]  <= (r_pperiod[i] == '0) ? 1'b0 : ~r_phase[i];
            end else begin
              r_phase[i] <= ~r_phase[i];
            end
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
          // running channel: hold the write until the next boundary
          if (w_wr[i]) begin
            r_pperiod[i] <= note_period;
            r_pvol[i]    <= note_vol;
`ifdef TONE_PAN_EN
            r_ppan[i]    <= note_pan;
`endif
            r_pend[i]    <= 1'b1;
          end
        end
      end
    end
  end

  // Sum the signed contributions of all running channels per side
  always_comb begin
    w_lsum = '0;
    w_rsum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_period[i] != '0) begin
`ifdef TONE_PAN_EN
        if (r_pan[i] != 2'b10) w_lsum = w_lsum + chan_amp(r_vol[i], r_phase[i]);
        if (r_pan[i] != 2'b01) w_rsum = w_rsum + chan_amp(r_vol[i], r_phase[i]);
`else
        w_lsum = w_lsum + chan_amp(r_vol[i], r_phase[i]);
        w_rsum = w_rsum + chan_amp(r_vol[i], r_phase[i]);
`endif
      end
    end
  end

  // Registered, saturated stereo output samples
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      LData <= '0;
      RData <= '0;
    end else begin
      LData <= sat_sample(w_lsum);
      RData <= sat_sample(w_rsum);
    end
  end

  // Tempo divider: strobe and beat count when the count reaches tempo_period
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_tcnt   <= '0;
      tempo    <= 1'b0;
      beat_cnt <= '0;
    end else if (tempo_period == '0) begin
      r_tcnt <= '0;
      tempo  <= 1'b0;
    end else if (r_tcnt == tempo_period) begin
      r_tcnt   <= '0;
      tempo    <= 1'b1;
      beat_cnt <= beat_cnt + 8'd1;
    end else if (r_tcnt > tempo_period) begin
      // period lowered below the running count: restart without a beat
      r_tcnt <= '0;
      tempo  <= 1'b0;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
      tempo  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tone_mixer_nch.sv
// Directed bench for tone_mixer_nch (NUM_CH=4, SAMPLE_W=16, A(vol 15)=30720).
module tb_tone_mixer_nch;

  localparam int AMP15 = 30720;

  logic               CLK;
  logic               RESET_N;
  logic               note_valid;
  logic               note_ready;
  logic [1:0]         note_ch;
  logic [19:0]        note_period;
  logic [3:0]         note_vol;
  logic [1:0]         note_pan;
  logic [25:0]        tempo_period;
  logic signed [15:0] LData;
  logic signed [15:0] RData;
  logic               tempo;
  logic [7:0]         beat_cnt;

  int n_chk = 0;
  int n_err = 0;

  tone_mixer_nch #(
    .NUM_CH(4), .DIV_W(20), .SAMPLE_W(16), .TEMPO_W(26)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .note_valid(note_valid), .note_ready(note_ready),
    .note_ch(note_ch), .note_period(note_period),
    .note_vol(note_vol), .note_pan(note_pan),
    .tempo_period(tempo_period),
    .LData(LData), .RData(RData),
    .tempo(tempo), .beat_cnt(beat_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] ch;
    logic [19:0] per;
    logic [3:0] vol;
    logic [1:0] pan;
    int         exp_l;
    int         exp_r;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic v, int ch, int per, int vol, int pan,
                              int el, int er);
    vec_t t;
    t.rst = r; t.vld = v; t.ch = 2'(ch); t.per = 20'(per);
    t.vol = 4'(vol); t.pan = 2'(pan); t.exp_l = el; t.exp_r = er;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_note(input logic v, input int ch, input int per, input int vol,
                          input int pan);
    note_valid  = v;
    note_ch     = 2'(ch);
    note_period = 20'(per);
    note_vol    = 4'(vol);
    note_pan    = 2'(pan);
  endtask

  // Asynchronous reset pulse from a negedge; checks outputs before any clock edge
  task automatic do_reset();
    note_valid = 1'b0;
    note_ch    = 2'd0;
    #1 RESET_N = 1'b0;
    #1;
    chk("rst_L", int'(LData), 0);
    chk("rst_R", int'(RData), 0);
    chk("rst_tempo", int'(tempo), 0);
    chk("rst_beat", int'(beat_cnt), 0);
    chk("rst_ready", int'(note_ready), 1);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    int el;
    int er;
    RESET_N      = 1'b1;
    tempo_period = '0;
    set_note(1'b0, 0, 0, 0, 0);
    #2 RESET_N = 1'b0;
    tick();
    tick();
    chk("por_L", int'(LData), 0);
    chk("por_R", int'(RData), 0);
    chk("por_tempo", int'(tempo), 0);
    chk("por_beat", int'(beat_cnt), 0);
    chk("por_ready", int'(note_ready), 1);
    RESET_N = 1'b1;

    // single tone: ch0 period 3 vol 15 both sides
    tbl.push_back(mk(1'b1, 1'b1, 0, 3, 15, 0, 0, 0));
    for (int k = 0; k < 10; k++) begin
      el = ((k / 3) % 2 == 0) ? AMP15 : -AMP15;
      tbl.push_back(mk(1'b0, 1'b0, 0, 0, 0, 0, el, el));
    end
    // ch2 vol 8 left only
    tbl.push_back(mk(1'b1, 1'b1, 2, 3, 8, 1, 0, 0));
    for (int k = 0; k < 6; k++) begin
      el = (k < 3) ? 16384 : -16384;
`ifdef TONE_PAN_EN
      er = 0;
`else
      er = el;
`endif
      tbl.push_back(mk(1'b0, 1'b0, 2, 0, 0, 0, el, er));
    end
    // ch3 vol 4 right only, period 2
    tbl.push_back(mk(1'b1, 1'b1, 3, 2, 4, 2, 0, 0));
    for (int k = 0; k < 4; k++) begin
      er = (k < 2) ? 8192 : -8192;
`ifdef TONE_PAN_EN
      el = 0;
`else
      el = er;
`endif
      tbl.push_back(mk(1'b0, 1'b0, 3, 0, 0, 0, el, er));
    end

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      set_note(tbl[i].vld, int'(tbl[i].ch), int'(tbl[i].per), int'(tbl[i].vol),
               int'(tbl[i].pan));
      tick();
      chk($sformatf("vec%0d_L", i), int'(LData), tbl[i].exp_l);
      chk($sformatf("vec%0d_R", i), int'(RData), tbl[i].exp_r);
      chk($sformatf("vec%0d_ready", i), int'(note_ready), 1);
    end

    // saturation: two full-volume channels one cycle apart
    do_reset();
    set_note(1'b1, 0, 5, 15, 0);
    tick();
    set_note(1'b1, 1, 5, 15, 0);
    tick();
    note_valid = 1'b0;
    chk("sat_first", int'(LData), AMP15);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sat_pos_L", int'(LData), 32767);
      chk("sat_pos_R", int'(RData), 32767);
    end
    tick();
    chk("sat_cancel", int'(LData), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sat_neg_L", int'(LData), -32768);
      chk("sat_neg_R", int'(RData), -32768);
    end
    tick();
    chk("sat_cancel2", int'(LData), 0);

    // pending retune: period 10 -> 4 written at cnt=2
    do_reset();
    set_note(1'b1, 0, 10, 15, 0);
    tick();
    note_valid = 1'b0;
    tick();
    tick();
    chk("rt_ready_pre", int'(note_ready), 1);
    set_note(1'b1, 0, 4, 15, 0);
    tick();
    chk("rt_ready_after_accept", int'(note_ready), 0);
    set_note(1'b1, 0, 4, 7, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rt_ready_stall", int'(note_ready), 0);
    end
    tick();
    chk("rt_ready_release", int'(note_ready), 1);
    chk("rt_last_pos", int'(LData), AMP15);
    note_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rt_neg_half", int'(LData), -AMP15);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rt_pos_half", int'(LData), AMP15);
    end
    tick();
    chk("rt_neg_again", int'(LData), -AMP15);

    // writing period 0 silences the channel at its next boundary
    set_note(1'b1, 0, 0, 0, 0);
    tick();
    note_valid = 1'b0;
    chk("sil_hold1", int'(LData), -AMP15);
    chk("sil_ready_pend", int'(note_ready), 0);
    tick();
    chk("sil_hold2", int'(LData), -AMP15);
    tick();
    chk("sil_hold3", int'(LData), -AMP15);
    chk("sil_ready_done", int'(note_ready), 1);
    tick();
    chk("sil_zero1", int'(LData), 0);
    tick();
    chk("sil_zero2", int'(LData), 0);

    // tempo: period 4 strobes every 5 cycles, with a tone running alongside
    do_reset();
    tempo_period = 26'd4;
    set_note(1'b1, 0, 3, 15, 0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      note_valid = 1'b0;
      chk($sformatf("tp_pulse%0d", k), int'(tempo), (k % 5 == 0) ? 1 : 0);
      chk($sformatf("tp_beat%0d", k), int'(beat_cnt), k / 5);
    end
    tempo_period = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("tp_off_pulse", int'(tempo), 0);
      chk("tp_off_beat", int'(beat_cnt), 3);
    end
    // lower the period below the running count: wrap without a strobe
    tempo_period = 26'd4;
    tick();
    tick();
    tick();
    tempo_period = 26'd1;
    tick();
    chk("tp_wrap_nostrobe", int'(tempo), 0);
    tick();
    chk("tp_wrap_count", int'(tempo), 0);
    tick();
    chk("tp_wrap_pulse", int'(tempo), 1);
    chk("tp_wrap_beat", int'(beat_cnt), 4);

    // pending write lost on a mid-note reset
    set_note(1'b1, 0, 7, 3, 0);
    tick();
    note_valid = 1'b0;
    chk("mid_ready_pend", int'(note_ready), 0);
    tempo_period = '0;
    do_reset();
    tick();
    tick();
    chk("mid_silent_L", int'(LData), 0);
    chk("mid_silent_R", int'(RData), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
